// File: rtl/aes_disp_pkg.sv
// rtl/aes_disp_pkg.sv - shared constants and types for the AES result pager
package aes_disp_pkg;

    localparam int STROBE_BIT = 0;
    localparam int IDX_LSB    = 1;
    localparam int IDX_W      = 2;
    localparam int LAST_BIT   = 3;
    localparam int NUM_WORDS  = 4;
    localparam int DIGITS     = 8;
    localparam int WORD_W     = 32;
    localparam int DATA_LSB   = 32;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [NUM_WORDS-1:0] mask_t;
    typedef logic [IDX_W-1:0]     widx_t;
    typedef logic [6:0]           seg_t;

    // Active-low segments, bit 6 = g down to bit 0 = a; entry 15 listed first
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg_t seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/convert_hex.sv
// rtl/convert_hex.sv - nibble to active-low seven-segment decoder
module convert_hex
    import aes_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_decode(nibble_i);

endmodule

// File: rtl/aes_result_pager.sv
// rtl/aes_result_pager.sv - assembles 128-bit AES results from PIO words and pages them onto eight hex digits
module aes_result_pager
    import aes_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000
)
(
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [63:0] pio_readdata,
    input  logic        key_next_n,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic [1:0]  page,
    output logic [7:0]  block_count,
    output logic        done,
    output logic        err
);

    localparam int             CW         = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL_CYCLES - 1);

    logic                            strobe_q,   strobe_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0] stage_q,    stage_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0] display_q,  display_d;
    mask_t                           mask_q,     mask_d;
    widx_t                           page_q,     page_d;
    logic [7:0]                      count_q,    count_d;
    logic [CW-1:0]                   dwell_q,    dwell_d;
    logic                            err_q,      err_d;
    logic                            done_q,     done_d;
    logic                            key_meta_q, key_sync_q, key_prev_q;

    logic   pio_event;
    logic   pio_last;
    widx_t  pio_idx;
    word_t  pio_word;
    mask_t  idx_onehot;
    mask_t  mask_with_idx;
    logic   commit;
    logic   incomplete;
    logic   key_press;
    logic   dwell_tc;
    logic   unused_ctrl;

    assign pio_word    = pio_readdata[DATA_LSB +: WORD_W];
    assign pio_idx     = pio_readdata[IDX_LSB +: IDX_W];
    assign pio_last    = pio_readdata[LAST_BIT];
    assign pio_event   = pio_readdata[STROBE_BIT] ^ strobe_q;
    assign unused_ctrl = ^pio_readdata[31:4];

    assign idx_onehot    = mask_t'(1) << pio_idx;
    assign mask_with_idx = mask_q | idx_onehot;
    assign commit        = pio_event & pio_last & (&mask_with_idx);
    assign incomplete    = pio_event & pio_last & ~(&mask_with_idx);

    assign key_press = key_prev_q & ~key_sync_q;
    assign dwell_tc  = (dwell_q == DWELL_LAST);

    always_comb begin
        strobe_d  = pio_readdata[STROBE_BIT];
        stage_d   = stage_q;
        mask_d    = mask_q;
        display_d = display_q;
        err_d     = err_q | incomplete;
        done_d    = commit;
        count_d   = count_q + {7'd0, commit};

        if (pio_event) begin
            stage_d[pio_idx] = pio_word;
            mask_d           = pio_last ? '0 : mask_with_idx;
        end
        // stage_d already holds the current word, which gives the bypass for free
        if (commit) begin
            display_d = stage_d;
        end
    end

    // Commit outranks both advance sources; a press and a terminal count together step once
    always_comb begin
        page_d  = page_q;
        dwell_d = dwell_q + CW'(1);
        if (commit) begin
            page_d  = '0;
            dwell_d = '0;
        end else if (key_press || dwell_tc) begin
            page_d  = page_q + widx_t'(1);
            dwell_d = '0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            strobe_q   <= 1'b0;
            stage_q    <= '0;
            display_q  <= '0;
            mask_q     <= '0;
            page_q     <= '0;
            count_q    <= '0;
            dwell_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_prev_q <= 1'b1;
        end else begin
            strobe_q   <= strobe_d;
            stage_q    <= stage_d;
            display_q  <= display_d;
            mask_q     <= mask_d;
            page_q     <= page_d;
            count_q    <= count_d;
            dwell_q    <= dwell_d;
            err_q      <= err_d;
            done_q     <= done_d;
            key_meta_q <= key_next_n;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    word_t                   page_word;
    logic [DIGITS-1:0][6:0]  seg;

    assign page_word = display_q[page_q];

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        convert_hex u_hex (
            .nibble_i (page_word[d*4 +: 4]),
            .seg_o    (seg[d])
        );
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];
    assign hex6 = seg[6];
    assign hex7 = seg[7];

    assign page        = page_q;
    assign block_count = count_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_aes_result_pager.sv
// tb/tb_aes_result_pager.sv - directed self-checking bench for aes_result_pager
module tb_aes_result_pager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pio;
    logic        key_n;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [1:0]  page;
    logic [7:0]  block_count;
    logic        done;
    logic        err;
    logic [55:0] hex_all;
    logic        tog;
    int          vectors    = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    aes_result_pager #(.DWELL_CYCLES(8)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_readdata  (pio),
        .key_next_n    (key_n),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5),
        .hex6          (hex6),
        .hex7          (hex7),
        .page          (page),
        .block_count   (block_count),
        .done          (done),
        .err           (err)
    );

    assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [55:0] exp_hex(input logic [31:0] w);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[i*7 +: 7] = seg7(w[i*4 +: 4]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] idx, input logic [31:0] data, input logic last);
        @(negedge clk);
        tog = ~tog;
        pio = {data, 28'd0, last, idx, tog};
    endtask

    task automatic send_block(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        send(2'd0, w0, 1'b0);
        send(2'd1, w1, 1'b0);
        send(2'd2, w2, 1'b0);
        send(2'd3, w3, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        pio   = '0;
        tog   = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        check("reset_hex_held", 64'(hex_all), 64'(exp_hex(32'h0)));
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_hex", 64'(hex_all), 64'(exp_hex(32'h0)));
        check("reset_hex0_const", 64'(hex0), 64'(7'b1000000));
        check("reset_page", 64'(page), 64'd0);
        check("reset_count", 64'(block_count), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        // Full block A, then auto-advance after exactly 8 cycles
        send_block(32'h8ea2b7ca, 32'h516745bf, 32'heafc4990, 32'h4b496089);
        @(negedge clk);
        check("a_done", 64'(done), 64'd1);
        check("a_count", 64'(block_count), 64'd1);
        check("a_page", 64'(page), 64'd0);
        check("a_hex", 64'(hex_all), 64'(exp_hex(32'h8ea2b7ca)));
        @(negedge clk);
        check("a_done_pulse", 64'(done), 64'd0);
        repeat (6) @(negedge clk);
        check("a_page_before_dwell", 64'(page), 64'd0);
        @(negedge clk);
        check("a_page_after_dwell", 64'(page), 64'd1);
        check("a_hex_page1", 64'(hex_all), 64'(exp_hex(32'h516745bf)));

        // Incomplete block: indices 0 and 2, then last on 3
        send(2'd0, 32'h11111111, 1'b0);
        send(2'd2, 32'h22222222, 1'b0);
        send(2'd3, 32'h33333333, 1'b1);
        @(negedge clk);
        check("inc_err", 64'(err), 64'd1);
        check("inc_done", 64'(done), 64'd0);
        check("inc_count", 64'(block_count), 64'd1);
        check("inc_page", 64'(page), 64'd1);
        check("inc_hex_kept", 64'(hex_all), 64'(exp_hex(32'h516745bf)));

        // Complete block B still commits
        send_block(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
        @(negedge clk);
        check("b_done", 64'(done), 64'd1);
        check("b_count", 64'(block_count), 64'd2);
        check("b_page", 64'(page), 64'd0);
        check("b_hex", 64'(hex_all), 64'(exp_hex(32'h00112233)));
        check("b_err_sticky", 64'(err), 64'd1);

        // Button: page steps 3 edges after raw fall, then dwell restarts from the press
        key_n = 1'b0;
        @(negedge clk);
        check("btn_edge1", 64'(page), 64'd0);
        @(negedge clk);
        check("btn_edge2", 64'(page), 64'd0);
        @(negedge clk);
        check("btn_edge3", 64'(page), 64'd1);
        check("btn_hex", 64'(hex_all), 64'(exp_hex(32'h44556677)));
        repeat (2) @(negedge clk);
        key_n = 1'b1;
        repeat (5) @(negedge clk);
        check("btn_once", 64'(page), 64'd1);
        @(negedge clk);
        check("btn_dwell_restart", 64'(page), 64'd2);

        // Press coinciding with a commit; last word arrives on index 0
        send(2'd1, 32'h89abcdef, 1'b0);
        send(2'd2, 32'hfedcba98, 1'b0);
        send(2'd3, 32'h76543210, 1'b0);
        @(negedge clk);
        key_n = 1'b0;
        @(negedge clk);
        send(2'd0, 32'h01234567, 1'b1);
        @(negedge clk);
        check("c_done", 64'(done), 64'd1);
        check("c_count", 64'(block_count), 64'd3);
        check("c_press_commit_page", 64'(page), 64'd0);
        check("c_hex", 64'(hex_all), 64'(exp_hex(32'h01234567)));
        @(negedge clk);
        check("c_page_hold", 64'(page), 64'd0);
        key_n = 1'b1;

        // Steady strobe level with changing data and control bits
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pio = {$urandom, 28'hABCDEF0, 1'b1, 2'(i), tog};
            check("steady_no_done", 64'(done), 64'd0);
        end
        @(negedge clk);
        check("steady_done_last", 64'(done), 64'd0);
        check("steady_count", 64'(block_count), 64'd3);

        // Block counter wrap
        for (int i = 0; i < 252; i++) begin
            send_block(32'(i), 32'(i + 1), 32'(i + 2), 32'(i + 3));
        end
        @(negedge clk);
        check("wrap_255", 64'(block_count), 64'd255);
        send_block(32'hfeedface, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("wrap_0", 64'(block_count), 64'd0);
        check("wrap_done", 64'(done), 64'd1);
        check("wrap_hex", 64'(hex_all), 64'(exp_hex(32'hfeedface)));

        // Reset mid-assembly, then a fresh block
        send(2'd0, 32'haaaaaaaa, 1'b0);
        send(2'd1, 32'hbbbbbbbb, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        tog   = 1'b0;
        pio   = '0;
        @(negedge clk);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_hex", 64'(hex_all), 64'(exp_hex(32'h0)));
        rst_n = 1'b1;
        send_block(32'hcafef00d, 32'h12345678, 32'h9abcdef0, 32'hdeadbeef);
        @(negedge clk);
        check("fresh_done", 64'(done), 64'd1);
        check("fresh_count", 64'(block_count), 64'd1);
        check("fresh_err", 64'(err), 64'd0);
        check("fresh_hex", 64'(hex_all), 64'(exp_hex(32'hcafef00d)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
